// File: rtl/dcr_fetch.sv
// Instruction fetch stage for the P3 core: PC register, imem request/ack handshake, IR capture, next-PC select.
// Optional DCR_FETCH_PERF_EN adds fetch/stall performance counters.
module dcr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              ClkInFU,
  input  logic              ResetNInFU,
  output logic              ImemReqOutFU,
  output logic [31:0]       ImemAddrOutFU,
  input  logic              ImemAckInFU,
  input  logic [31:0]       ImemDataInFU,
  input  logic              StallInFU,
  input  logic [1:0]        PCSrcInFU,
  input  logic [15:0]       BranchOffInFU,
  input  logic [25:0]       JumpTargInFU,
  input  logic [31:0]       RegTargInFU,
  output logic [31:0]       InstrOutFU,
  output logic              InstrValidOutFU,
  output logic [5:0]        OpcodeOutFU,
  output logic [4:0]        RtOutFU,
  output logic [5:0]        FuncOutFU,
  output logic [31:0]       PCOutFU,
`ifdef DCR_FETCH_PERF_EN
  output logic [CNT_W-1:0]  FetchCntOutFU,
  output logic [CNT_W-1:0]  StallCntOutFU,
`endif
  output logic [31:0]       PCPlus4OutFU
);

  typedef enum logic [0:0] {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        unused_regtarg_s;

  assign pc_plus4_s       = pc_q + 32'd4;
  assign unused_regtarg_s = ^RegTargInFU[1:0];

  // Next-PC select, only consumed on the HOLD->FETCH edge.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (PCSrcInFU)
      2'b00:   next_pc_s = pc_plus4_s;
      2'b01:   next_pc_s = pc_plus4_s + {{14{BranchOffInFU[15]}}, BranchOffInFU, 2'b00};
      2'b10:   next_pc_s = {pc_plus4_s[31:28], JumpTargInFU, 2'b00};
      2'b11:   next_pc_s = {RegTargInFU[31:2], 2'b00};
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // Fetch FSM next-state: capture on ack in FETCH, advance PC on consume in HOLD.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        if (ImemAckInFU) begin
          ir_d    = ImemDataInFU;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!StallInFU) begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and instruction register.
  always_ff @(posedge ClkInFU or negedge ResetNInFU) begin
    if (!ResetNInFU) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Gating with reset drops the request the instant reset asserts.
  assign ImemReqOutFU    = (state_q == FETCH) && ResetNInFU;
  assign ImemAddrOutFU   = pc_q;
  assign InstrOutFU      = ir_q;
  assign InstrValidOutFU = valid_q;
  assign OpcodeOutFU     = ir_q[31:26];
  assign RtOutFU         = ir_q[20:16];
  assign FuncOutFU       = ir_q[5:0];
  assign PCOutFU         = pc_q;
  assign PCPlus4OutFU    = pc_plus4_s;

`ifdef DCR_FETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counter increments: accepted fetch acks and stalled HOLD cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == FETCH) && ImemAckInFU) begin
      fetch_cnt_d = fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if ((state_q == HOLD) && StallInFU) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge ClkInFU or negedge ResetNInFU) begin
    if (!ResetNInFU) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCntOutFU = fetch_cnt_q;
  assign StallCntOutFU = stall_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

endmodule

// File: tb/tb_dcr_fetch.sv
// Directed self-checking bench for dcr_fetch: reset, handshake timing, stall, next-PC vector table, mid-fetch reset.
module tb_dcr_fetch;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [15:0] boff;
  logic [25:0] jtarg;
  logic [31:0] rtarg;
  logic [31:0] instr;
  logic        ivalid;
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc4;
`ifdef DCR_FETCH_PERF_EN
  logic [31:0] fcnt;
  logic [31:0] scnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_fetches = 0;

  dcr_fetch dut (
    .ClkInFU(clk), .ResetNInFU(rst_n),
    .ImemReqOutFU(req), .ImemAddrOutFU(addr),
    .ImemAckInFU(ack), .ImemDataInFU(data),
    .StallInFU(stall), .PCSrcInFU(pcsrc),
    .BranchOffInFU(boff), .JumpTargInFU(jtarg), .RegTargInFU(rtarg),
    .InstrOutFU(instr), .InstrValidOutFU(ivalid),
    .OpcodeOutFU(opcode), .RtOutFU(rt), .FuncOutFU(func),
    .PCOutFU(pc),
`ifdef DCR_FETCH_PERF_EN
    .FetchCntOutFU(fcnt), .StallCntOutFU(scnt),
`endif
    .PCPlus4OutFU(pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] off;
    logic [25:0] targ;
    logic [31:0] regt;
    logic [31:0] word;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Garbage on next-PC inputs: must be ignored outside the consume edge.
  task automatic scramble();
    pcsrc = 2'b11; boff = 16'h1234; jtarg = 26'h2AA_AAAA; rtarg = 32'hDEAD_BEEF;
  endtask

  task automatic fetch_word(input logic [31:0] w, input int waits, input logic [31:0] exp_a);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", {31'd0, req}, 32'd1);
      chk("wait_addr", addr, exp_a);
      chk("wait_valid", {31'd0, ivalid}, 32'd0);
      data = 32'hBAD0_0000 + i;
      tick();
    end
    chk("ack_req", {31'd0, req}, 32'd1);
    chk("ack_addr", addr, exp_a);
    ack = 1'b1; data = w;
    tick();
    exp_fetches++;
    ack = 1'b1; data = ~w;
    chk("ir", instr, w);
    chk("ir_valid", {31'd0, ivalid}, 32'd1);
    chk("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
    chk("rt", {27'd0, rt}, {27'd0, w[20:16]});
    chk("func", {26'd0, func}, {26'd0, w[5:0]});
    chk("hold_req", {31'd0, req}, 32'd0);
    chk("pc", pc, exp_a);
    chk("pc4", pc4, exp_a + 32'd4);
  endtask

  task automatic consume(input logic [1:0] s, input logic [15:0] o, input logic [25:0] t, input logic [31:0] r);
    stall = 1'b0; pcsrc = s; boff = o; jtarg = t; rtarg = r;
    tick();
    ack = 1'b0;
    scramble();
    chk("post_valid", {31'd0, ivalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held_ir;
    vecs[0] = '{2'b11, 16'h0000, 26'h0, 32'h0000_0103, 32'h8C22_0010, 32'h0000_0100};
    vecs[1] = '{2'b01, 16'hFFFF, 26'h0, 32'h0, 32'h1000_FFFF, 32'h0000_0100};
    vecs[2] = '{2'b10, 16'h0000, 26'h000_0040, 32'h0, 32'h0800_0040, 32'h0000_0100};
    vecs[3] = '{2'b11, 16'h0000, 26'h0, 32'h0000_1007, 32'h0060_0008, 32'h0000_1004};
    vecs[4] = '{2'b01, 16'h8000, 26'h0, 32'h0, 32'h0411_8000, 32'hFFFE_1008};
    vecs[5] = '{2'b10, 16'h0000, 26'h3FF_FFFF, 32'h0, 32'h0FFF_FFFF, 32'hFFFF_FFFC};
    vecs[6] = '{2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'b01, 16'h0010, 26'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0044};
    vecs[8] = '{2'b11, 16'h0000, 26'h0, 32'h8000_0002, 32'hAC3F_0004, 32'h8000_0000};
    vecs[9] = '{2'b10, 16'h0000, 26'h123_4567, 32'h0, 32'h0C00_0009, 32'h848D_159C};

    rst_n = 1'b0; ack = 1'b0; data = 32'h0; stall = 1'b0;
    scramble();
    #12;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_valid", {31'd0, ivalid}, 32'd0);
    chk("rst_pc", addr, 32'h0);
    chk("rst_fields", {15'd0, opcode, rt, func}, 32'h0);
`ifdef DCR_FETCH_PERF_EN
    chk("rst_fcnt", fcnt, 32'd0);
    chk("rst_scnt", scnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    #1;

    // Zero-wait: addresses 0, 4, 8; ack held high in HOLD must be ignored.
    fetch_word(32'h2008_0005, 0, 32'h0);
    consume(2'b00, 16'h0, 26'h0, 32'h0);
    fetch_word(32'h2009_0006, 0, 32'h4);
    consume(2'b00, 16'h0, 26'h0, 32'h0);
    chk("addr8", addr, 32'h8);

    // Ack delayed 3 cycles.
    fetch_word(32'h1234_5678, 3, 32'h8);

    // Stall in HOLD for 5 cycles with acks arriving.
    held_ir = instr;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ack = i[0]; data = 32'h5555_0000 + i;
      tick();
      chk("stall_ir", instr, held_ir);
      chk("stall_pc", pc, 32'h8);
      chk("stall_req", {31'd0, req}, 32'd0);
      chk("stall_valid", {31'd0, ivalid}, 32'd1);
    end
`ifdef DCR_FETCH_PERF_EN
    chk("stall_cnt", scnt, 32'd5);
`endif
    consume(2'b00, 16'h0, 26'h0, 32'h0);
    chk("addr_c", addr, 32'hC);

    // Stall asserted during FETCH has no effect.
    stall = 1'b1;
    fetch_word(32'h0000_0021, 1, 32'hC);
    stall = 1'b0;

    begin
      logic [31:0] cur;
      cur = 32'hC;
      for (int v = 0; v < 10; v++) begin
        if (v > 0) fetch_word(vecs[v].word, v % 3, cur);
        consume(vecs[v].src, vecs[v].off, vecs[v].targ, vecs[v].regt);
        chk($sformatf("vec%0d_addr", v), addr, vecs[v].exp_addr);
        cur = vecs[v].exp_addr;
      end
    end
`ifdef DCR_FETCH_PERF_EN
    chk("fetch_cnt", fcnt, exp_fetches);
`endif

    // Reset asserted mid-request.
    tick();
    chk("pre_rst_req", {31'd0, req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, req}, 32'd0);
    chk("midrst_pc", addr, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    exp_fetches = 0;
    chk("rel_req", {31'd0, req}, 32'd1);
    chk("rel_addr", addr, 32'h0);
`ifdef DCR_FETCH_PERF_EN
    chk("rel_fcnt", fcnt, 32'd0);
    chk("rel_scnt", scnt, 32'd0);
`endif
    fetch_word(32'h2008_0005, 0, 32'h0);
    consume(2'b00, 16'h0, 26'h0, 32'h0);
    chk("restart_addr", addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
